// File: rtl/lane_frame_loader_pkg.sv
// rtl/lane_frame_loader_pkg.sv - shared constants and types for the lane frame loader
package lane_frame_loader_pkg;

  // Frame geometry: DEPTH samples of LANES lanes, W bits per sample
  localparam int LANES       = 8;
  localparam int DEPTH       = 32;
  localparam int W           = 8;
  localparam int FRAME_BYTES = LANES * DEPTH;

  // Index widths; LANES and DEPTH are powers of two so byte index splits into sample/lane fields
  localparam int LANE_IDX_W   = $clog2(LANES);
  localparam int SAMPLE_IDX_W = $clog2(DEPTH);
  localparam int WR_IDX_W     = $clog2(FRAME_BYTES);
  localparam int RD_IDX_W     = $clog2(DEPTH);

  // One output beat: lane i in bits [W*i+W-1 : W*i]
  typedef logic [LANES*W-1:0] lane_vec_t;
  typedef logic [W-1:0]       sample_t;

endpackage

// File: rtl/frame_bank.sv
// rtl/frame_bank.sv - one ping-pong bank, byte-wide writes, lane-vector reads
module frame_bank
  import lane_frame_loader_pkg::*;
#(
  parameter int N_LANES = LANES,
  parameter int N_DEPTH = DEPTH,
  parameter int N_W     = W
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [$clog2(N_DEPTH)-1:0] wr_sample,
  input  logic [$clog2(N_LANES)-1:0] wr_lane,
  input  logic [N_W-1:0]             wr_data,
  input  logic [$clog2(N_DEPTH)-1:0] rd_sample,
  output logic [N_LANES*N_W-1:0]     rd_data
);

  // Storage is deliberately left uncleared by reset; the full flags in the top guard it
  logic [N_W-1:0] mem [N_DEPTH][N_LANES];

  // Byte write into (sample, lane)
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_sample][wr_lane] <= wr_data;
    end
  end

  // Combinational read of all lanes of one sample
  always_comb begin
    rd_data = '0;
    for (int l = 0; l < N_LANES; l++) begin
      rd_data[l*N_W +: N_W] = mem[rd_sample][l];
    end
  end

endmodule

// File: rtl/lane_frame_loader.sv
// rtl/lane_frame_loader.sv - serial byte to parallel lane frame loader with ping-pong banks
module lane_frame_loader
  import lane_frame_loader_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [W-1:0]    s_data,
  input  logic            s_last,
  output logic            m_valid,
  input  logic            m_ready,
  output lane_vec_t       m_data,
  output logic            m_first,
  output logic            m_last,
  output logic            frame_err,
  output logic [15:0]     frame_cnt
);

  localparam logic [WR_IDX_W-1:0] WR_LAST = WR_IDX_W'(FRAME_BYTES - 1);
  localparam logic [RD_IDX_W-1:0] RD_LAST = RD_IDX_W'(DEPTH - 1);

  logic [1:0]          full;
  logic                wr_bank;
  logic                rd_bank;
  logic [WR_IDX_W-1:0] wr_idx;
  logic [RD_IDX_W-1:0] rd_idx;

  logic                wr_fire;
  logic                rd_fire;
  lane_vec_t           bank_rd_data [2];

  // Writer only ever targets an empty bank, reader only a full one
  assign s_ready = !full[wr_bank];
  assign m_valid = full[rd_bank];
  assign wr_fire = s_valid && s_ready;
  assign rd_fire = m_valid && m_ready;

  // Beat flags and data are forced to zero when no frame is presented
  assign m_first = m_valid && (rd_idx == '0);
  assign m_last  = m_valid && (rd_idx == RD_LAST);
  assign m_data  = m_valid ? bank_rd_data[rd_bank] : '0;

  // Byte k lands at sample k/LANES, lane k%LANES
  for (genvar b = 0; b < 2; b++) begin : g_bank
    frame_bank u_bank (
      .clk       (clk),
      .wr_en     (wr_fire && (wr_bank == 1'(b))),
      .wr_sample (wr_idx[WR_IDX_W-1:LANE_IDX_W]),
      .wr_lane   (wr_idx[LANE_IDX_W-1:0]),
      .wr_data   (s_data),
      .rd_sample (rd_idx),
      .rd_data   (bank_rd_data[b])
    );
  end

  // Ping-pong control: fill completion, early-last discard, beat release
  always_ff @(posedge clk) begin
    if (rst) begin
      full      <= 2'b00;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      frame_err <= 1'b0;
      frame_cnt <= 16'd0;
    end else begin
      frame_err <= 1'b0;

      if (wr_fire) begin
        if (wr_idx == WR_LAST) begin
          // Full frame is kept even if s_last is missing on its final byte
          full[wr_bank] <= 1'b1;
          wr_bank       <= !wr_bank;
          wr_idx        <= '0;
          frame_err     <= !s_last;
        end else if (s_last) begin
          // Short frame: drop it and restart filling the same bank
          wr_idx    <= '0;
          frame_err <= 1'b1;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
      end

      if (rd_fire) begin
        if (rd_idx == RD_LAST) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= !rd_bank;
          rd_idx        <= '0;
          frame_cnt     <= frame_cnt + 16'd1;
        end else begin
          rd_idx <= rd_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lane_frame_loader.sv
// tb/tb_lane_frame_loader.sv - directed self-checking bench for lane_frame_loader
module tb_lane_frame_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = 8'd0;
  logic        s_last = 1'b0;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_data;
  logic        m_first;
  logic        m_last;
  logic        frame_err;
  logic [15:0] frame_cnt;

  typedef struct {
    logic [63:0] data;
    logic        first;
    logic        last;
    int          cyc;
  } beat_t;

  beat_t       beats[$];
  int          checks = 0;
  int          errors = 0;
  int          m_mode = 0;
  int          cyc = 0;
  int          err_pulses = 0;
  int          stall_breaks = 0;
  int          stalls_seen = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data = '0;
  logic        prev_first = 1'b0;
  logic        prev_last = 1'b0;

  lane_frame_loader dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_first   (m_first),
    .m_last    (m_last),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte k of frame with seed s
  function automatic logic [7:0] byte_val(input int seed, input int k);
    return 8'((k + seed * 37) & 255);
  endfunction

  // Expected beat j: lane i carries byte j*8+i
  function automatic logic [63:0] exp_beat(input int seed, input int j);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = byte_val(seed, j * 8 + i);
    return r;
  endfunction

  // Downstream model: drives m_ready, records beats that will transfer, watches stalls and error pulses
  initial begin
    m_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (m_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (prev_stall && m_valid &&
          (m_data !== prev_data || m_first !== prev_first || m_last !== prev_last))
        stall_breaks++;
      if (m_valid && !m_ready) stalls_seen++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_first = m_first;
      prev_last  = m_last;
      if (frame_err === 1'b1) err_pulses++;
      if (m_valid === 1'b1 && m_ready && !rst)
        beats.push_back('{data: m_data, first: m_first, last: m_last, cyc: cyc});
    end
  end

  task automatic apply_reset();
    m_mode  = 0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    beats.delete();
    err_pulses   = 0;
    stall_breaks = 0;
    stalls_seen  = 0;
    prev_stall   = 1'b0;
  endtask

  task automatic send_frame(input int seed, input int nbytes, input int last_idx);
    int t;
    for (int k = 0; k < nbytes; k++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = byte_val(seed, k);
      s_last  = (k == last_idx);
      t = 0;
      while (!s_ready && t < 3000) begin
        @(negedge clk);
        t++;
      end
      if (!s_ready) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: seed %0d byte %0d s_ready=%b required 1", seed, k, s_ready);
        s_valid = 1'b0;
        s_last  = 1'b0;
        return;
      end
      @(posedge clk);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int t;
    t = 0;
    while (beats.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (beats.size() < n) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: got %0d beats required %0d", beats.size(), n);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (s_ready !== 1'b1)    begin errors++; $display("FAIL reset_s_ready: got %b required 1", s_ready); end
    checks++; if (m_valid !== 1'b0)    begin errors++; $display("FAIL reset_m_valid: got %b required 0", m_valid); end
    checks++; if (m_first !== 1'b0)    begin errors++; $display("FAIL reset_m_first: got %b required 0", m_first); end
    checks++; if (m_last !== 1'b0)     begin errors++; $display("FAIL reset_m_last: got %b required 0", m_last); end
    checks++; if (frame_err !== 1'b0)  begin errors++; $display("FAIL reset_frame_err: got %b required 0", frame_err); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d required 0", frame_cnt); end
    checks++; if (m_data !== 64'd0)    begin errors++; $display("FAIL reset_m_data: got %h required 0", m_data); end
  endtask

  task automatic test_single_frame();
    apply_reset();
    m_mode = 1;
    send_frame(0, 256, 255);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL latency_m_valid: got %b required 1", m_valid); end
    checks++; if (m_first !== 1'b1) begin errors++; $display("FAIL latency_m_first: got %b required 1", m_first); end
    wait_beats(32);
    if (beats.size() >= 32) begin
      checks++; if (beats[0].data !== 64'h0706050403020100)
        begin errors++; $display("FAIL single_beat0: got %h required 0706050403020100", beats[0].data); end
      checks++; if (beats[31].data !== 64'hFFFEFDFCFBFAF9F8)
        begin errors++; $display("FAIL single_beat31: got %h required fffefdfcfbfaf9f8", beats[31].data); end
      for (int j = 0; j < 32; j++) begin
        checks++; if (beats[j].data !== exp_beat(0, j))
          begin errors++; $display("FAIL single_data beat %0d: got %h required %h", j, beats[j].data, exp_beat(0, j)); end
        checks++; if (beats[j].first !== (j == 0) || beats[j].last !== (j == 31))
          begin errors++; $display("FAIL single_flags beat %0d: got first=%b last=%b required %b %b", j, beats[j].first, beats[j].last, j == 0, j == 31); end
        checks++; if (beats[j].cyc !== beats[0].cyc + j)
          begin errors++; $display("FAIL single_bubble beat %0d: got cycle %0d required %0d", j, beats[j].cyc, beats[0].cyc + j); end
      end
    end
    checks++; if (beats.size() !== 32) begin errors++; $display("FAIL single_count: got %0d beats required 32", beats.size()); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL single_frame_cnt: got %0d required 1", frame_cnt); end
    checks++; if (err_pulses !== 0)    begin errors++; $display("FAIL single_frame_err: got %0d pulses required 0", err_pulses); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    m_mode = 0;
    send_frame(1, 256, 255);
    send_frame(2, 256, 255);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL b2b_s_ready_full: got %b required 0", s_ready); end
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL b2b_m_valid: got %b required 1", m_valid); end
    fork
      send_frame(3, 256, 255);
      begin
        repeat (10) @(negedge clk);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL b2b_s_ready_hold: got %b required 0", s_ready); end
        checks++; if (beats.size() !== 0) begin errors++; $display("FAIL b2b_no_early_beats: got %0d required 0", beats.size()); end
        m_mode = 1;
      end
    join
    wait_beats(96);
    if (beats.size() >= 96) begin
      for (int f = 0; f < 3; f++) begin
        for (int j = 0; j < 32; j++) begin
          checks++; if (beats[f*32+j].data !== exp_beat(f + 1, j))
            begin errors++; $display("FAIL b2b_data frame %0d beat %0d: got %h required %h", f, j, beats[f*32+j].data, exp_beat(f + 1, j)); end
        end
      end
    end
    checks++; if (beats.size() !== 96) begin errors++; $display("FAIL b2b_count: got %0d beats required 96", beats.size()); end
    checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL b2b_frame_cnt: got %0d required 3", frame_cnt); end
  endtask

  task automatic test_random_stall();
    apply_reset();
    m_mode = 2;
    send_frame(0, 256, 255);
    wait_beats(32);
    if (beats.size() >= 32) begin
      for (int j = 0; j < 32; j++) begin
        checks++; if (beats[j].data !== exp_beat(0, j) || beats[j].first !== (j == 0) || beats[j].last !== (j == 31))
          begin errors++; $display("FAIL stall_beat %0d: got %h f=%b l=%b required %h", j, beats[j].data, beats[j].first, beats[j].last, exp_beat(0, j)); end
      end
    end
    checks++; if (stall_breaks !== 0) begin errors++; $display("FAIL stall_hold: got %0d changes during stall required 0", stall_breaks); end
    checks++; if (stalls_seen < 1)    begin errors++; $display("FAIL stall_exercised: got %0d stalls required >0", stalls_seen); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL stall_frame_cnt: got %0d required 1", frame_cnt); end
  endtask

  task automatic test_early_last();
    apply_reset();
    m_mode = 1;
    send_frame(9, 101, 100);
    repeat (40) @(negedge clk);
    checks++; if (err_pulses !== 1)   begin errors++; $display("FAIL early_err_pulse: got %0d pulses required 1", err_pulses); end
    checks++; if (beats.size() !== 0) begin errors++; $display("FAIL early_no_frame: got %0d beats required 0", beats.size()); end
    checks++; if (s_ready !== 1'b1)   begin errors++; $display("FAIL early_s_ready: got %b required 1", s_ready); end
    send_frame(5, 256, 255);
    wait_beats(32);
    if (beats.size() >= 32) begin
      for (int j = 0; j < 32; j++) begin
        checks++; if (beats[j].data !== exp_beat(5, j))
          begin errors++; $display("FAIL early_next_data beat %0d: got %h required %h", j, beats[j].data, exp_beat(5, j)); end
      end
    end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL early_frame_cnt: got %0d required 1", frame_cnt); end
    checks++; if (err_pulses !== 1)    begin errors++; $display("FAIL early_err_total: got %0d pulses required 1", err_pulses); end
  endtask

  task automatic test_missing_last();
    apply_reset();
    m_mode = 1;
    send_frame(6, 256, -1);
    wait_beats(32);
    checks++; if (err_pulses !== 1) begin errors++; $display("FAIL nolast_err_pulse: got %0d pulses required 1", err_pulses); end
    if (beats.size() >= 32) begin
      for (int j = 0; j < 32; j++) begin
        checks++; if (beats[j].data !== exp_beat(6, j))
          begin errors++; $display("FAIL nolast_data beat %0d: got %h required %h", j, beats[j].data, exp_beat(6, j)); end
      end
    end
    checks++; if (beats.size() !== 32) begin errors++; $display("FAIL nolast_count: got %0d beats required 32", beats.size()); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL nolast_frame_cnt: got %0d required 1", frame_cnt); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    m_mode = 0;
    send_frame(7, 256, 255);
    send_frame(8, 128, -1);
    m_mode = 1;
    wait_beats(10);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (m_valid !== 1'b0)    begin errors++; $display("FAIL midrst_m_valid: got %b required 0", m_valid); end
    checks++; if (s_ready !== 1'b1)    begin errors++; $display("FAIL midrst_s_ready: got %b required 1", s_ready); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL midrst_frame_cnt: got %0d required 0", frame_cnt); end
    checks++; if (m_data !== 64'd0)    begin errors++; $display("FAIL midrst_m_data: got %h required 0", m_data); end
    rst = 1'b0;
    m_mode = 0;
    @(negedge clk);
    beats.delete();
    m_mode = 1;
    send_frame(10, 256, 255);
    wait_beats(32);
    if (beats.size() >= 32) begin
      for (int j = 0; j < 32; j++) begin
        checks++; if (beats[j].data !== exp_beat(10, j) || beats[j].first !== (j == 0) || beats[j].last !== (j == 31))
          begin errors++; $display("FAIL midrst_fresh beat %0d: got %h required %h", j, beats[j].data, exp_beat(10, j)); end
      end
    end
    checks++; if (beats.size() !== 32) begin errors++; $display("FAIL midrst_count: got %0d beats required 32", beats.size()); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL midrst_frame_cnt_after: got %0d required 1", frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_random_stall();
    test_early_last();
    test_missing_last();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
